// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: operation encodings and op width.
package pc_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_INC  = 3'd0;
  localparam logic [OP_W-1:0] OP_BR   = 3'd1;
  localparam logic [OP_W-1:0] OP_JMP  = 3'd2;
  localparam logic [OP_W-1:0] OP_CALL = 3'd3;
  localparam logic [OP_W-1:0] OP_RET  = 3'd4;

endpackage

// File: rtl/pc_addsub.sv
// Combinational add/subtract with one extra bit; carry is carry-out on add, borrow on subtract.
module pc_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] w_res;

  always_comb begin
    if (sub) begin
      w_res = {1'b0, a} - {1'b0, b};
    end else begin
      w_res = {1'b0, a} + {1'b0, b};
    end
  end

  assign sum   = w_res[WIDTH-1:0];
  assign carry = w_res[WIDTH];

endmodule

// File: rtl/pc_unit.sv
// Registered program counter with inc/branch/jump/call/return and wrap flag.
// Define PC_RAS_EN to build the circular return-address stack behind CALL/RET.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               STEP      = 1,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [OP_W-1:0]  op,
  input  logic             decr,
  input  logic [WIDTH-1:0] diff,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             wrapped,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] r_pc;
  logic             r_wrapped;
  logic             r_ras_err;

  logic             w_is_br;
  logic [WIDTH-1:0] w_add_b;
  logic             w_add_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_pc_next;
  logic             w_wrap_next;
  logic             w_err_next;

  // One adder serves INC, BR, the CALL return address and the RET fallback.
  assign w_is_br   = (op == OP_BR);
  assign w_add_b   = w_is_br ? diff : STEP_W;
  assign w_add_sub = w_is_br & decr;

  pc_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (r_pc),
    .b     (w_add_b),
    .sub   (w_add_sub),
    .sum   (w_sum),
    .carry (w_carry)
  );

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_ptr_top;
  logic [WIDTH-1:0] w_top;
  logic             w_ras_empty;
  logic             w_ras_full;
  logic             w_push;
  logic             w_pop;

  assign w_ras_empty = (r_count == '0);
  assign w_ras_full  = (r_count == CNT_W'(RAS_DEPTH));
  assign w_ptr_top   = r_ptr - PTR_W'(1);
  assign w_top       = r_ras[w_ptr_top];
  assign w_push      = en && (op == OP_CALL);
  assign w_pop       = en && (op == OP_RET) && !w_ras_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[r_ptr] <= w_sum;
    end
  end

  // Pushing while full wraps the pointer onto the oldest entry; count saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (!w_ras_full) begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (w_pop) begin
      r_ptr   <= w_ptr_top;
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign ras_empty = w_ras_empty;
  assign ras_full  = w_ras_full;
`else
  // Stack depth only matters when the stack is built.
  if (RAS_DEPTH < 2) begin : g_ras_depth_unused
  end

  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
`endif

  always_comb begin
    w_pc_next   = r_pc;
    w_wrap_next = 1'b0;
    w_err_next  = 1'b0;
    case (op)
      OP_INC, OP_BR: begin
        w_pc_next   = w_sum;
        w_wrap_next = w_carry;
      end
      OP_JMP, OP_CALL: begin
        w_pc_next = target;
      end
      OP_RET: begin
`ifdef PC_RAS_EN
        if (w_ras_empty) begin
          w_pc_next  = w_sum;
          w_err_next = 1'b1;
        end else begin
          w_pc_next = w_top;
        end
`else
        w_pc_next   = w_sum;
        w_wrap_next = w_carry;
`endif
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_VEC;
      r_wrapped <= 1'b0;
      r_ras_err <= 1'b0;
    end else begin
      r_wrapped <= en & w_wrap_next;
      r_ras_err <= en & w_err_next;
      if (en) begin
        r_pc <= w_pc_next;
      end
    end
  end

  assign pc      = r_pc;
  assign pc_next = w_pc_next;
  assign wrapped = r_wrapped;
  assign ras_err = r_ras_err;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: fixed vector table, random branch sweep, RAS sequence, async reset.
module tb_pc_unit;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [2:0]  op;
  logic        decr;
  logic [15:0] diff;
  logic [15:0] target;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic        wrapped;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;

  always #5 clk = ~clk;

  pc_unit #(
    .WIDTH     (16),
    .RESET_VEC (16'h0100),
    .STEP      (1),
    .RAS_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .op        (op),
    .decr      (decr),
    .diff      (diff),
    .target    (target),
    .pc        (pc),
    .pc_next   (pc_next),
    .wrapped   (wrapped),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_err   (ras_err)
  );

  typedef struct {
    logic [15:0] pc;
    logic        wrapped;
    logic        err;
    logic        empty;
    logic        full;
  } exp_t;

  typedef struct {
    logic        en;
    logic [2:0]  op;
    logic        decr;
    logic [15:0] diff;
    logic [15:0] target;
    logic [15:0] exp_next;
    logic [15:0] exp_pc;
    logic        exp_wrap;
  } vec_t;

  exp_t        sb[$];
  logic [15:0] m_ras[$];
  logic [15:0] m_pc;
  vec_t        vecs[13];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one cycle; expectations come from the table when tbl=1, else from the model.
  task automatic drive(input logic e, input logic [2:0] o, input logic d,
                       input logic [15:0] df, input logic [15:0] tg,
                       input bit tbl, input logic [15:0] t_next,
                       input logic [15:0] t_pc, input logic t_wrap);
    int          s;
    logic [15:0] nx;
    logic        wr;
    logic        er;
    exp_t        x;
    en = e; op = o; decr = d; diff = df; target = tg;
    nx = m_pc; wr = 1'b0; er = 1'b0;
    case (o)
      OP_INC: begin
        s = int'(m_pc) + 1; nx = s[15:0]; wr = (s > 65535);
      end
      OP_BR: begin
        if (d) begin
          s = int'(m_pc) - int'(df); nx = s[15:0]; wr = (df > m_pc);
        end else begin
          s = int'(m_pc) + int'(df); nx = s[15:0]; wr = (s > 65535);
        end
      end
      OP_JMP, OP_CALL: nx = tg;
      OP_RET: begin
`ifdef PC_RAS_EN
        if (m_ras.size() == 0) begin
          s = int'(m_pc) + 1; nx = s[15:0]; er = 1'b1;
        end else begin
          nx = m_ras[m_ras.size()-1];
        end
`else
        s = int'(m_pc) + 1; nx = s[15:0]; wr = (s > 65535);
`endif
      end
      default: nx = m_pc;
    endcase
    #1;
    chk("pc_next", pc_next, tbl ? t_next : nx);
    if (e) begin
`ifdef PC_RAS_EN
      if (o == OP_CALL) begin
        m_ras.push_back(m_pc + 16'd1);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
      if (o == OP_RET && m_ras.size() > 0) void'(m_ras.pop_back());
`endif
      m_pc = nx;
    end else begin
      wr = 1'b0;
      er = 1'b0;
    end
    x.pc      = tbl ? t_pc : m_pc;
    x.wrapped = tbl ? t_wrap : wr;
    x.err     = er;
`ifdef PC_RAS_EN
    x.empty = (m_ras.size() == 0);
    x.full  = (m_ras.size() == 4);
`else
    x.empty = 1'b1;
    x.full  = 1'b0;
`endif
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      x = sb.pop_front();
      chk("pc", pc, x.pc);
      chk("wrapped", wrapped, x.wrapped);
      chk("ras_err", ras_err, x.err);
      chk("ras_empty", ras_empty, x.empty);
      chk("ras_full", ras_full, x.full);
    end
    $display("op=%0d en=%0b decr=%0b diff=%h target=%h -> pc=%h wrapped=%0b err=%0b empty=%0b full=%0b",
             o, e, d, df, tg, pc, wrapped, ras_err, ras_empty, ras_full);
  endtask

  task automatic step(input logic e, input logic [2:0] o, input logic d,
                      input logic [15:0] df, input logic [15:0] tg);
    drive(e, o, d, df, tg, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, pc, 16'h0100);
    chk({tag, "_wrapped"}, wrapped, 1'b0);
    chk({tag, "_ras_err"}, ras_err, 1'b0);
    chk({tag, "_ras_empty"}, ras_empty, 1'b1);
    chk({tag, "_ras_full"}, ras_full, 1'b0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; op = OP_INC; decr = 1'b0; diff = '0; target = '0;
    m_pc = 16'h0100;
    #1;
    check_reset_state("reset_init");
    @(posedge clk);
    #1;
    reset = 1'b0;

    //         en    op       decr  diff      target    next      pc        wrap
    vecs[0]  = '{1'b1, OP_JMP, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[1]  = '{1'b1, OP_INC, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[2]  = '{1'b1, OP_BR,  1'b1, 16'h0003, 16'h0000, 16'hFFFD, 16'hFFFD, 1'b1};
    vecs[3]  = '{1'b1, OP_JMP, 1'b0, 16'h0000, 16'h1234, 16'h1234, 16'h1234, 1'b0};
    vecs[4]  = '{1'b1, OP_BR,  1'b0, 16'h0010, 16'h0000, 16'h1244, 16'h1244, 1'b0};
    vecs[5]  = '{1'b1, OP_BR,  1'b1, 16'h0044, 16'h0000, 16'h1200, 16'h1200, 1'b0};
    vecs[6]  = '{1'b0, OP_JMP, 1'b0, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h1200, 1'b0};
    vecs[7]  = '{1'b0, OP_JMP, 1'b0, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h1200, 1'b0};
    vecs[8]  = '{1'b0, OP_JMP, 1'b0, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h1200, 1'b0};
    vecs[9]  = '{1'b1, OP_JMP, 1'b0, 16'h0000, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b0};
    vecs[10] = '{1'b1, 3'd6,   1'b0, 16'h0000, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0};
    vecs[11] = '{1'b1, OP_INC, 1'b0, 16'h0000, 16'h0000, 16'hBEF0, 16'hBEF0, 1'b0};
    vecs[12] = '{1'b1, OP_BR,  1'b0, 16'h4110, 16'h0000, 16'h0000, 16'h0000, 1'b1};

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].en, vecs[i].op, vecs[i].decr, vecs[i].diff, vecs[i].target,
            1'b1, vecs[i].exp_next, vecs[i].exp_pc, vecs[i].exp_wrap);
    end

    // Random branch sweep against the modulo-2^16 model.
    for (int i = 0; i < 256; i++) begin
      logic [15:0] p;
      logic [15:0] df;
      logic        d;
      p  = 16'($urandom);
      df = 16'($urandom);
      d  = 1'($urandom_range(0, 1));
      step(1'b1, OP_JMP, 1'b0, 16'h0, p);
      step(1'b1, OP_BR, d, df, 16'h0);
    end

    // Five nested calls into a depth-4 stack, then five returns.
    step(1'b1, OP_JMP, 1'b0, 16'h0, 16'h0010);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, OP_CALL, 1'b0, 16'h0, 16'(i * 16'h0100));
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, OP_RET, 1'b0, 16'h0, 16'h0);
    end
`ifdef PC_RAS_EN
    chk("ret_underflow_pc", pc, 16'h0102);
    chk("ret_underflow_err", ras_err, 1'b1);
`else
    chk("ret_as_inc_pc", pc, 16'h0505);
    chk("ret_as_inc_err", ras_err, 1'b0);
`endif
    step(1'b1, OP_INC, 1'b0, 16'h0, 16'h0);

    // Reset mid-stream with a live stack entry and en=1, op=INC.
    step(1'b1, OP_CALL, 1'b0, 16'h0, 16'h0700);
    step(1'b1, OP_INC, 1'b0, 16'h0, 16'h0);
    reset = 1'b1;
    #1;
    check_reset_state("reset_mid");
    m_pc = 16'h0100;
    m_ras.delete();
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_hold_pc", pc, 16'h0100);
    step(1'b1, OP_INC, 1'b0, 16'h0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

endmodule
